// File: rtl/dm_store_arbiter_if.sv
// Bus bundle between the M-stage store/load logic, the store buffer and the single DM port.
interface dm_store_arbiter_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_grant;
    logic        ld_stall;
    logic        dm_ready;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic        sb_empty;

    modport master (
        output st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, dm_ready,
        input  st_ready, ld_grant, ld_stall, dm_addr, dm_byteen, dm_wdata, sb_empty
    );

    modport slave (
        input  st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, dm_ready,
        output st_ready, ld_grant, ld_stall, dm_addr, dm_byteen, dm_wdata, sb_empty
    );
endinterface

// File: rtl/dm_store_arbiter.sv
// Store buffer and DM-port arbiter: loads bypass queued stores unless they hit a pending word.
// Optional write combining into the youngest entry when DM_STORE_ARBITER_WCOMB_EN is defined.
module dm_store_arbiter #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned StarveLimit = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    dm_store_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned StW  = $clog2(StarveLimit + 1);

    logic [29:0]     addr_q [Depth];
    logic [3:0]      be_q   [Depth];
    logic [31:0]     data_q [Depth];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, young;
    logic [CntW-1:0] count_q, count_d;
    logic [StW-1:0]  starve_q, starve_d;

    logic        full, empty, force_drain, head_drive, pop, push, alloc, merge;
    logic        hazard, hazard_buf, hazard_push, st_ready, ld_grant;
    logic [29:0] st_word;
    logic [31:0] dm_addr, dm_wdata, merged_data;
    logic [3:0]  dm_byteen;
    logic        unused_addr_lsbs;

    assign st_word          = bus.st_addr[31:2];
    assign full             = (count_q == CntW'(Depth));
    assign empty            = (count_q == '0);
    assign young            = tail_q - PtrW'(1);
    assign force_drain      = (starve_q == StW'(StarveLimit)) && !empty;
    assign unused_addr_lsbs = ^bus.st_addr[1:0];

    always_comb begin
        hazard_buf = 1'b0;
        for (int k = 0; k < int'(Depth); k++) begin
            if ((CntW'(k) < count_q) && (addr_q[head_q + PtrW'(k)] == bus.ld_addr[31:2])) begin
                hazard_buf = 1'b1;
            end
        end
    end

`ifdef DM_STORE_ARBITER_WCOMB_EN
    // Push-side hazard ignores st_ready so the arbitration never depends on the merge decision.
    assign hazard_push = bus.st_valid && (bus.st_byteen != 4'b0) && (st_word == bus.ld_addr[31:2]);
    assign merge = bus.st_valid && (bus.st_byteen != 4'b0) && !empty &&
                   (addr_q[young] == st_word) && !(pop && (count_q == CntW'(1)));
    assign st_ready = !full || merge;
`else
    assign hazard_push = push && (st_word == bus.ld_addr[31:2]);
    assign merge       = 1'b0;
    assign st_ready    = !full;
`endif

    assign push   = bus.st_valid && st_ready && (bus.st_byteen != 4'b0);
    assign alloc  = push && !merge;
    assign hazard = bus.ld_valid && (hazard_buf || hazard_push);

    always_comb begin
        head_drive = 1'b0;
        ld_grant   = 1'b0;
        dm_addr    = '0;
        dm_byteen  = '0;
        dm_wdata   = '0;
        if (force_drain) begin
            head_drive = 1'b1;
        end else if (bus.ld_valid && !hazard) begin
            ld_grant = 1'b1;
            dm_addr  = bus.ld_addr;
        end else if (!empty) begin
            head_drive = 1'b1;
        end
        if (head_drive) begin
            dm_addr   = {addr_q[head_q], 2'b00};
            dm_byteen = be_q[head_q];
            dm_wdata  = data_q[head_q];
        end
    end

    assign pop = head_drive && bus.dm_ready;

    always_comb begin
        merged_data = data_q[young];
        for (int b = 0; b < 4; b++) begin
            if (bus.st_byteen[b]) merged_data[8*b +: 8] = bus.st_wdata[8*b +: 8];
        end
    end

    always_comb begin
        head_d = pop ? head_q + PtrW'(1) : head_q;
        tail_d = alloc ? tail_q + PtrW'(1) : tail_q;
        unique case ({alloc, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (pop || empty) begin
            starve_d = '0;
        end else if (ld_grant && (starve_q != StW'(StarveLimit))) begin
            starve_d = starve_q + StW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage needs no reset: validity comes from head/count only.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            addr_q[tail_q] <= st_word;
            be_q[tail_q]   <= bus.st_byteen;
            data_q[tail_q] <= bus.st_wdata;
        end else if (merge) begin
            be_q[young]   <= be_q[young] | bus.st_byteen;
            data_q[young] <= merged_data;
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.ld_grant  = ld_grant;
    assign bus.ld_stall  = bus.ld_valid && !ld_grant;
    assign bus.dm_addr   = dm_addr;
    assign bus.dm_byteen = dm_byteen;
    assign bus.dm_wdata  = dm_wdata;
    assign bus.sb_empty  = empty;
endmodule

// File: doc/dm_store_arbiter.md
Name: dm_store_arbiter

Overview:
- Store buffer and port arbiter between the M-stage store byte-enable logic and the single data-memory port.
- Queues stores, already formatted as address, byte enable and write data, in a FIFO.
- Lets loads use the port ahead of queued stores, and stalls any load that reads a word still pending in the buffer.
- Bounds store starvation with a counter and provides an empty flag for fences and syscalls.

Parameters:
DEPTH, 4, number of store-buffer entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked-drain cycles before a store drain is forced (>=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  M stage presents a store
st_addr  input  32  store byte address; only [31:2] is stored
st_byteen  input  4  formatted byte enable; 4'b0000 is never pushed
st_wdata  input  32  formatted (lane-shifted) write data
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  M stage presents a load
ld_addr  input  32  load byte address
ld_grant  output  1  load owns the DM port this cycle; read data is valid combinationally
ld_stall  output  1  load must hold and retry; pipeline freezes M and earlier
dm_ready  input  1  memory accepts a write this cycle
dm_addr  output  32  port address
dm_byteen  output  4  port write enables; 0 means no write
dm_wdata  output  32  port write data
sb_empty  output  1  no pending stores

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, count and starve counter go to 0.
  - Outputs: st_ready=1, sb_empty=1, ld_grant=0, ld_stall=0, dm_byteen=0, dm_addr=0, dm_wdata=0.
- Storage: circular FIFO of DEPTH entries {word_addr[29:0], byteen[3:0], wdata[31:0]}; head and tail wrap modulo DEPTH; count ranges 0..DEPTH.
- st_ready = (count != DEPTH). It is a function of registered state only. A pop in the same cycle does not free a slot.
- Push: on the edge where st_valid && st_ready && st_byteen!=0. A store with st_byteen=0 is acknowledged and dropped.
- Hazard (combinational): ld_valid and ld_addr[31:2] equals word_addr of any valid entry, or of a store being pushed this cycle.
- Arbitration, evaluated each cycle in priority order:
  1. force_drain = (starve_cnt == STARVE_LIMIT) && count!=0. Head entry drives the port; ld_grant=0; ld_stall=ld_valid.
  2. Load with no hazard: ld_grant=1; dm_addr=ld_addr; dm_byteen=0.
  3. Otherwise, if count!=0: head drives the port with dm_addr={word_addr,2'b00}, dm_byteen, dm_wdata; ld_stall=ld_valid (hazard or no grant).
  4. Otherwise: idle, dm_byteen=0.
- Pop: on the edge where the head drives the port and dm_ready=1.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - If dm_ready=0 the head is held and re-presented unchanged.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each edge where count!=0 and a load is granted.
  - Clears on every pop and whenever count==0.
- Latency: a pushed store can drain on the first cycle after the push edge. Memory is written no earlier than 1 cycle after acceptance.
- Write ordering: memory writes occur strictly in push order.
- Loads never observe stale data, because of the hazard stall.
- sb_empty = (count==0), registered-state based.
- A reset asserted mid-operation discards all pending stores.

Optional Feature:
- Macro: DM_STORE_ARBITER_WCOMB_EN.
- Defined:
  - A push whose st_addr[31:2] equals the youngest valid entry's word_addr merges into that entry instead of allocating.
  - Merge rule: byteen |= st_byteen; for each lane set in st_byteen, that data byte is replaced.
  - Merging is allowed only when the youngest entry is not the head being popped this cycle; otherwise a normal push occurs.
  - A merge succeeds even when the buffer is full, so st_ready = !full || merge_hit.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset with reset=0 mid-stream holding 3 entries -> all outputs at reset values, sb_empty=1; after release no writes occur.
- Push sw 0x100/1111/0xDEADBEEF, dm_ready=1, no loads -> next cycle dm_addr=0x100, dm_byteen=1111, dm_wdata=0xDEADBEEF; sb_empty=1 after the pop.
- Push 4 stores with dm_ready=0 -> st_ready=0; a 5th store is held. Raise dm_ready -> drains in push order, pointers wrap, st_ready=1 after the first pop.
- Buffer holds sb to 0x203 (byteen 1000); load 0x200 -> ld_stall=1 until that entry pops, then ld_grant=1.
- One entry pending, load to an unrelated address every cycle, STARVE_LIMIT=8 -> 8 load grants, then a forced drain with ld_stall=1 for that cycle, then grants resume.
- WCOMB_EN: sb 0x301/0x00AA00(byteen 0010) then sb 0x302/0xBB0000(byteen 0100), dm_ready=0 -> one entry, byteen 0110, data 0x00BBAA00. Without the macro -> two entries.
